clk_phase_decoder: RTL and testbench

- Receiver-side counterpart of the CPU phase generator: samples `clk2`, `clk4`, `fetch` and `alu_clk`, and reconstructs the 8-step instruction-cycle index.
- Emits one-hot step enables and fetch/ALU strobes for the multi-cycle datapath, so control logic runs on the main clock instead of derived clocks.
- Detects loss of phase alignment and counts errors.

---
 rtl/clk_phase_decoder_if.sv | 35 +++
 rtl/clk_phase_decoder.sv | 153 +++++++++++++++
 tb/tb_clk_phase_decoder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/clk_phase_decoder_if.sv
// Bundle between the CPU phase generator side and clk_phase_decoder.
//
// Phase inputs (driven by master):
//   clk2_in, clk4_in, fetch_in, alu_clk_in : raw generator phase levels
// Decoded outputs (driven by slave):
//   step_onehot[7:0], step_idx[2:0]        : current step while locked
//   fetch_en, alu_en                       : 1-cycle strobes at step 3 / step 0
//   locked                                 : phase lock achieved
//   phase_err                              : 1-cycle pulse on phase mismatch
//   err_cnt[ERR_W-1:0]                     : saturating mismatch count
interface clk_phase_decoder_if #(
    parameter int ERR_W = 8
);
    logic             clk2_in;
    logic             clk4_in;
    logic             fetch_in;
    logic             alu_clk_in;
    logic [7:0]       step_onehot;
    logic [2:0]       step_idx;
    logic             fetch_en;
    logic             alu_en;
    logic             locked;
    logic             phase_err;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output clk2_in, clk4_in, fetch_in, alu_clk_in,
        input  step_onehot, step_idx, fetch_en, alu_en, locked, phase_err, err_cnt
    );

    modport slave (
        input  clk2_in, clk4_in, fetch_in, alu_clk_in,
        output step_onehot, step_idx, fetch_en, alu_en, locked, phase_err, err_cnt
    );
endinterface

// File: rtl/clk_phase_decoder.sv
// Reconstructs the 8-step instruction-cycle index from the sampled phase
// generator outputs, producing main-clock step enables and strobes, and
// detecting / counting loss of phase alignment.
//
// Ports:
//   clk   : system clock, all logic on posedge
//   reset : synchronous, active-high
//   bus   : clk_phase_decoder_if.slave (phase inputs, decoded outputs)
module clk_phase_decoder #(
    parameter int LOCK_PERIODS = 2,
    parameter int ERR_W        = 8,
    parameter int CHECK_ALU    = 1
) (
    input logic                 clk,
    input logic                 reset,
    clk_phase_decoder_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, HUNT, VERIFY, LOCKED} state_t;

    localparam logic [6:0] CHK_LIMIT = 7'(8 * LOCK_PERIODS);

    state_t     state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic [6:0] chk, chk_nx;

    logic s_clk2, s_clk4, s_fetch, s_alu;
    logic h_clk2, h_clk4, h_fetch, h_alu;
    logic t_clk2, t_clk4, t_fetch, t_alu;
    logic match, err_nx;

    logic [7:0]       onehot_r;
    logic [2:0]       idx_r;
    logic             fetch_en_r, alu_en_r, locked_r, phase_err_r;
    logic [ERR_W-1:0] err_cnt_r;

    assign t_clk2  = s_clk2  ^ h_clk2;
    assign t_clk4  = s_clk4  ^ h_clk4;
    assign t_fetch = s_fetch ^ h_fetch;
    assign t_alu   = s_alu   ^ h_alu;

    // Toggle vector compared against the expected pattern for step cnt.
    always_comb begin
        match = t_clk2
             && (t_clk4  == cnt[0])
             && (t_fetch == (cnt == 3'd3))
             && ((CHECK_ALU == 0) || (t_alu == (cnt <= 3'd1)));
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        chk_nx   = chk;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (t_clk2) state_nx = HUNT;
            end
            HUNT: begin
                if (!t_clk2) begin
                    state_nx = IDLE;
                end else if (t_fetch) begin
                    // The fetch toggle marks step 3; checking resumes at step 4.
                    state_nx = VERIFY;
                    cnt_nx   = 3'd4;
                    chk_nx   = '0;
                end
            end
            VERIFY: begin
                if (!match) begin
                    err_nx   = 1'b1;
                    state_nx = HUNT;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 3'd1;
                    chk_nx = chk + 7'd1;
                    if (chk + 7'd1 == CHK_LIMIT) state_nx = LOCKED;
                end
            end
            LOCKED: begin
                if (!match) begin
                    err_nx   = 1'b1;
                    state_nx = HUNT;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            chk         <= '0;
            s_clk2      <= 1'b0;
            s_clk4      <= 1'b0;
            s_fetch     <= 1'b0;
            s_alu       <= 1'b0;
            h_clk2      <= 1'b0;
            h_clk4      <= 1'b0;
            h_fetch     <= 1'b0;
            h_alu       <= 1'b0;
            onehot_r    <= '0;
            idx_r       <= '0;
            fetch_en_r  <= 1'b0;
            alu_en_r    <= 1'b0;
            locked_r    <= 1'b0;
            phase_err_r <= 1'b0;
            err_cnt_r   <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            chk     <= chk_nx;
            s_clk2  <= bus.clk2_in;
            s_clk4  <= bus.clk4_in;
            s_fetch <= bus.fetch_in;
            s_alu   <= bus.alu_clk_in;
            h_clk2  <= s_clk2;
            h_clk4  <= s_clk4;
            h_fetch <= s_fetch;
            h_alu   <= s_alu;
            // Outputs publish the step just checked, gated by the state being
            // entered so locked and the step outputs rise and fall together.
            if (state_nx == LOCKED) begin
                locked_r   <= 1'b1;
                idx_r      <= cnt;
                onehot_r   <= 8'd1 << cnt;
                fetch_en_r <= (cnt == 3'd3);
                alu_en_r   <= (cnt == 3'd0);
            end else begin
                locked_r   <= 1'b0;
                idx_r      <= '0;
                onehot_r   <= '0;
                fetch_en_r <= 1'b0;
                alu_en_r   <= 1'b0;
            end
            phase_err_r <= err_nx;
            if (err_nx && (err_cnt_r != '1)) err_cnt_r <= err_cnt_r + 1'b1;
        end
    end

    assign bus.step_onehot = onehot_r;
    assign bus.step_idx    = idx_r;
    assign bus.fetch_en    = fetch_en_r;
    assign bus.alu_en      = alu_en_r;
    assign bus.locked      = locked_r;
    assign bus.phase_err   = phase_err_r;
    assign bus.err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_clk_phase_decoder.sv
// Scoreboard bench for clk_phase_decoder. Three instances share one phase
// generator: u0 (CHECK_ALU=1, ERR_W=8), u1 (CHECK_ALU=0, ERR_W=8) and
// u2 (CHECK_ALU=1, ERR_W=2). A drive issued in cycle c is checked by the DUT
// at the edge ending cycle c+1 and its result is visible in cycle c+2.
module tb_clk_phase_decoder;

    logic clk = 1'b0;
    logic reset;
    logic g2, g4, gf, ga;

    always #5 clk = ~clk;

    clk_phase_decoder_if #(.ERR_W(8)) bus0 ();
    clk_phase_decoder_if #(.ERR_W(8)) bus1 ();
    clk_phase_decoder_if #(.ERR_W(2)) bus2 ();

    assign bus0.clk2_in = g2;  assign bus0.clk4_in = g4;
    assign bus0.fetch_in = gf; assign bus0.alu_clk_in = ga;
    assign bus1.clk2_in = g2;  assign bus1.clk4_in = g4;
    assign bus1.fetch_in = gf; assign bus1.alu_clk_in = ga;
    assign bus2.clk2_in = g2;  assign bus2.clk4_in = g4;
    assign bus2.fetch_in = gf; assign bus2.alu_clk_in = ga;

    clk_phase_decoder #(.LOCK_PERIODS(2), .ERR_W(8), .CHECK_ALU(1)) u0 (
        .clk(clk), .reset(reset), .bus(bus0));
    clk_phase_decoder #(.LOCK_PERIODS(2), .ERR_W(8), .CHECK_ALU(0)) u1 (
        .clk(clk), .reset(reset), .bus(bus1));
    clk_phase_decoder #(.LOCK_PERIODS(2), .ERR_W(2), .CHECK_ALU(1)) u2 (
        .clk(clk), .reset(reset), .bus(bus2));

    logic [7:0] oh [3];
    logic [2:0] ix [3];
    logic       fe [3], ae [3], lk [3], pe [3];
    logic [7:0] ec [3];

    assign oh[0] = bus0.step_onehot; assign oh[1] = bus1.step_onehot; assign oh[2] = bus2.step_onehot;
    assign ix[0] = bus0.step_idx;    assign ix[1] = bus1.step_idx;    assign ix[2] = bus2.step_idx;
    assign fe[0] = bus0.fetch_en;    assign fe[1] = bus1.fetch_en;    assign fe[2] = bus2.fetch_en;
    assign ae[0] = bus0.alu_en;      assign ae[1] = bus1.alu_en;      assign ae[2] = bus2.alu_en;
    assign lk[0] = bus0.locked;      assign lk[1] = bus1.locked;      assign lk[2] = bus2.locked;
    assign pe[0] = bus0.phase_err;   assign pe[1] = bus1.phase_err;   assign pe[2] = bus2.phase_err;
    assign ec[0] = bus0.err_cnt;     assign ec[1] = bus1.err_cnt;     assign ec[2] = {6'b0, bus2.err_cnt};

    typedef struct {
        int       due;
        int       dut;
        bit       lk;
        bit [2:0] idx;
        bit       pe;
        int       ec;
    } exp_t;

    exp_t sb [$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops every expectation due this cycle and compares.
    exp_t       cur;
    logic [7:0] e_oh;
    logic [2:0] e_ix;
    logic       e_fe, e_ae;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            cur = sb.pop_front();
            checks++;
            if (cur.due != cyc) begin
                failures++;
                $display("FAIL sb_stale dut%0d due=%0d now=%0d", cur.dut, cur.due, cyc);
            end else begin
                e_ix = cur.lk ? cur.idx : 3'd0;
                e_oh = cur.lk ? (8'd1 << cur.idx) : 8'd0;
                e_fe = cur.lk && (cur.idx == 3'd3);
                e_ae = cur.lk && (cur.idx == 3'd0);
                if ({lk[cur.dut], ix[cur.dut], oh[cur.dut], fe[cur.dut], ae[cur.dut], pe[cur.dut]}
                        !== {cur.lk, e_ix, e_oh, e_fe, e_ae, cur.pe}
                    || ec[cur.dut] !== 8'(cur.ec)) begin
                    failures++;
                    $display("FAIL outputs dut%0d cyc=%0d got lk=%b idx=%0d oh=%b fe=%b ae=%b pe=%b ec=%0d expected lk=%b idx=%0d oh=%b fe=%b ae=%b pe=%b ec=%0d",
                             cur.dut, cyc, lk[cur.dut], ix[cur.dut], oh[cur.dut], fe[cur.dut],
                             ae[cur.dut], pe[cur.dut], ec[cur.dut],
                             cur.lk, e_ix, e_oh, e_fe, e_ae, cur.pe, cur.ec);
                end
            end
        end
    end

    int gstep;
    bit alu_on;
    int jj;
    int lock_j;
    int ecx [3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int due, input int dut, input bit l, input int k,
                        input bit p, input int e);
        exp_t x;
        x.due = due; x.dut = dut; x.lk = l; x.idx = 3'(k); x.pe = p; x.ec = e;
        sb.push_back(x);
    endtask

    // Generator: toggles the phase levels for the current step.
    task automatic gen(input bit drop2, input bit xfetch, output int c, output int k);
        tick();
        c = cyc;
        k = gstep;
        if (!drop2) g2 = ~g2;
        if (k % 2 == 1) g4 = ~g4;
        if (k == 3 || xfetch) gf = ~gf;
        if (alu_on && k <= 1) ga = ~ga;
        gstep = (gstep + 1) % 8;
    endtask

    task automatic do_reset();
        int c;
        tick();
        reset = 1'b1;
        g2 = 1'b0; g4 = 1'b0; gf = 1'b0; ga = 1'b0;
        gstep = 0;
        sb.delete();
        c = cyc;
        for (int d = 0; d < 3; d++) push(c + 1, d, 1'b0, 0, 1'b0, 0);
        for (int d = 0; d < 3; d++) push(c + 2, d, 1'b0, 0, 1'b0, 0);
        tick();
        tick();
        reset = 1'b0;
        jj = 0;
        for (int d = 0; d < 3; d++) ecx[d] = 0;
    endtask

    task automatic run_clean(input int n);
        int c, k;
        for (int i = 0; i < n; i++) begin
            gen(1'b0, 1'b0, c, k);
            for (int d = 0; d < 3; d++) push(c + 2, d, jj >= lock_j, k, 1'b0, ecx[d]);
            jj++;
        end
    endtask

    task automatic fault(input bit drop2, input bit xfetch);
        int c, k;
        gen(drop2, xfetch, c, k);
        for (int d = 0; d < 3; d++) begin
            if (ecx[d] < ((d == 2) ? 3 : 255)) ecx[d]++;
            push(c + 2, d, 1'b0, 0, 1'b1, ecx[d]);
        end
        jj++;
    endtask

    initial begin
        int c, k, n;
        reset = 1'b1;
        g2 = 1'b0; g4 = 1'b0; gf = 1'b0; ga = 1'b0;
        alu_on = 1'b1;
        gstep = 0;
        do_reset();

        // Nominal: fetch at drive 3, 16 clean checks (drives 4..19).
        lock_j = 19;
        run_clean(45);
        // Drive 45 is step 5: clk2 held.
        fault(1'b1, 1'b0);
        // Next fetch at drive 51 (step 3); locked from drive 51+16.
        lock_j = 67;
        run_clean(24);
        // Drive 70 is step 6: extra fetch toggle.
        fault(1'b0, 1'b1);
        // Next fetch at drive 75; locked from drive 75+16.
        lock_j = 91;
        run_clean(30);

        // Reset at the drive that would be step 5 while locked.
        do_reset();

        // alu_clk stuck: u1 locks normally; u0/u2 fail every step-0 check
        // from drive 8 on (8, 16, 24, ...), never locking.
        alu_on = 1'b0;
        for (int i = 0; i < 44; i++) begin
            gen(1'b0, 1'b0, c, k);
            push(c + 2, 1, jj >= 19, k, 1'b0, 0);
            n = jj / 8;
            push(c + 2, 0, 1'b0, 0, (k == 0) && (jj >= 8), n);
            push(c + 2, 2, 1'b0, 0, (k == 0) && (jj >= 8), (n > 3) ? 3 : n);
            jj++;
        end
        repeat (4) tick();

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout cyc=%0d expected completion", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
